me_arbiter: RTL and testbench

Arbiter that shares the single read/write port of the ME data memory between the pipeline MEM stage (primary requester) and a secondary memory master (loader/DMA/debug) using a valid/ready handshake. The CPU wins by default with zero added latency. A starvation counter forces a one-cycle DMA grant and stalls the CPU after a bounded wait. The block sits between the MEM stage, the DMA master and the ME instance. ME's second read port (`extra_address`/`extra_dout`) is not routed through this block.

---
 rtl/me_arb_pkg.sv | 15 +
 rtl/me_arb_fsm.sv | 77 +++++++
 rtl/me_arbiter.sv | 98 +++++++++
 tb/tb_me_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_arb_pkg.sv
// Shared types and constants for the ME data-memory arbiter.
// Arbitration states and the access-size encoding that ME understands.
package me_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_BYTE = 2'b10;

endpackage

// File: rtl/me_arb_fsm.sv
// Starvation tracker: counts consecutive cycles a pending DMA request loses to the CPU
// and raises force_grant for exactly one cycle once the limit is reached.
module me_arb_fsm
   import me_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             cpu_req,
   input  logic             dma_valid,
   output logic             force_grant,
   output arb_state_t       state,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + ONE_C;
      case (state_q)
         IDLE: begin
            if (dma_valid && cpu_req) begin
               cnt_d = ONE_C;
               if (LIMIT_C == ONE_C) begin
                  state_d = FORCE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Either the DMA got through on a CPU-free cycle, or it withdrew its request.
            if (!dma_valid || !cpu_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == LIMIT_C) begin
                  state_d = FORCE;
               end
            end
         end
         FORCE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign force_grant = (state_q == FORCE);
   assign state       = state_q;
   assign cnt         = cnt_q;

endmodule

// File: rtl/me_arbiter.sv
// Shares ME's single read/write port between the MEM stage (default winner, zero latency)
// and a valid/ready DMA master, with a bounded-wait forced grant for the DMA side.
module me_arbiter
   import me_arb_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_mode,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_stall,
   input  logic              dma_valid,
   input  logic              dma_we,
   input  logic [1:0]        dma_mode,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_din,
   output logic              dma_ready,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              me_memwrite,
   output logic [1:0]        me_mode,
   output logic [ADDR_W-1:0] me_address,
   output logic [DATA_W-1:0] me_din,
   input  logic [DATA_W-1:0] me_dout,
   output arb_state_t        dbg_state,
   output logic [CNT_W-1:0]  dbg_cnt
);

   // Handshake: dma_valid and the dma_* payload stay stable until dma_ready;
   // a transfer happens on the rising edge where both are high.

   logic              force_grant;
   logic              grant_dma;
   logic              dma_rvalid_q, dma_rvalid_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   me_arb_fsm #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_fsm (
      .clk         (clk),
      .RST         (RST),
      .cpu_req     (cpu_req),
      .dma_valid   (dma_valid),
      .force_grant (force_grant),
      .state       (dbg_state),
      .cnt         (dbg_cnt)
   );

   assign grant_dma = dma_valid && (!cpu_req || force_grant);
   assign dma_ready = grant_dma;
   assign cpu_stall = cpu_req && grant_dma;
   assign cpu_dout  = me_dout;

   // A stalled CPU write never reaches ME: the DMA owns the port that cycle.
   always_comb begin
      me_memwrite = cpu_req && cpu_we;
      me_mode     = cpu_mode;
      me_address  = cpu_addr;
      me_din      = cpu_din;
      if (grant_dma) begin
         me_memwrite = dma_we;
         me_mode     = dma_mode;
         me_address  = dma_addr;
         me_din      = dma_din;
      end
   end

   always_comb begin
      dma_rvalid_d = grant_dma && !dma_we;
      dma_rdata_d  = dma_rdata_q;
      if (grant_dma && !dma_we) begin
         dma_rdata_d = me_dout;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         dma_rvalid_q <= dma_rvalid_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign dma_rvalid = dma_rvalid_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_me_arbiter.sv
// Directed bench for me_arbiter: one instance with STARVE_LIMIT=8, one with STARVE_LIMIT=1,
// each backed by a small behavioural ME (combinational read, clocked write).
module tb_me_arbiter;
   import me_arb_pkg::*;

   logic clk;
   logic rst;

   logic        cpu_req, cpu_we, dma_valid, dma_we;
   logic [1:0]  cpu_mode, dma_mode;
   logic [11:0] cpu_addr, dma_addr;
   logic [31:0] cpu_din, dma_din;

   logic [31:0] cpu_dout0, dma_rdata0, me_din0, me_dout0;
   logic        cpu_stall0, dma_ready0, dma_rvalid0, me_memwrite0;
   logic [1:0]  me_mode0;
   logic [11:0] me_address0;
   arb_state_t  st0;
   logic [7:0]  cnt0;

   logic [31:0] cpu_dout1, dma_rdata1, me_din1, me_dout1;
   logic        cpu_stall1, dma_ready1, dma_rvalid1, me_memwrite1;
   logic [1:0]  me_mode1;
   logic [11:0] me_address1;
   arb_state_t  st1;
   logic [7:0]  cnt1;

   logic [31:0] mem0 [0:4095];
   logic [31:0] mem1 [0:4095];

   int total = 0;
   int bad   = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   me_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(8), .CNT_W(8)) u_dut0 (
      .clk(clk), .RST(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout0), .cpu_stall(cpu_stall0),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_mode(dma_mode), .dma_addr(dma_addr),
      .dma_din(dma_din), .dma_ready(dma_ready0), .dma_rvalid(dma_rvalid0), .dma_rdata(dma_rdata0),
      .me_memwrite(me_memwrite0), .me_mode(me_mode0), .me_address(me_address0),
      .me_din(me_din0), .me_dout(me_dout0), .dbg_state(st0), .dbg_cnt(cnt0)
   );

   me_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .RST(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout1), .cpu_stall(cpu_stall1),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_mode(dma_mode), .dma_addr(dma_addr),
      .dma_din(dma_din), .dma_ready(dma_ready1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
      .me_memwrite(me_memwrite1), .me_mode(me_mode1), .me_address(me_address1),
      .me_din(me_din1), .me_dout(me_dout1), .dbg_state(st1), .dbg_cnt(cnt1)
   );

   assign me_dout0 = mem0[me_address0];
   assign me_dout1 = mem1[me_address1];

   always @(posedge clk) begin
      if (me_memwrite0) mem0[me_address0] <= me_din0;
      if (me_memwrite1) mem1[me_address1] <= me_din1;
   end

   // checker
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cpu(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
      cpu_req  = req;
      cpu_we   = we;
      cpu_mode = MODE_WORD;
      cpu_addr = a;
      cpu_din  = d;
   endtask

   task automatic drive_dma(input logic v, input logic we, input logic [11:0] a, input logic [31:0] d);
      dma_valid = v;
      dma_we    = we;
      dma_mode  = MODE_WORD;
      dma_addr  = a;
      dma_din   = d;
   endtask

   initial begin
      rst = 1'b1;
      drive_cpu(1'b0, 1'b0, 12'h000, 32'h0);
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("rst_state", 64'(st0), 64'(IDLE));
      chk("rst_cnt", 64'(cnt0), 64'd0);
      chk("rst_rvalid", 64'(dma_rvalid0), 64'd0);
      chk("rst_rdata", 64'(dma_rdata0), 64'd0);
      chk("rst_ready", 64'(dma_ready0), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // DMA-only: write then read back 0x010
      drive_dma(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
      #1;
      chk("dw_ready", 64'(dma_ready0), 64'd1);
      chk("dw_memwrite", 64'(me_memwrite0), 64'd1);
      chk("dw_addr", 64'(me_address0), 64'h010);
      tick();
      drive_dma(1'b1, 1'b0, 12'h010, 32'h0);
      #1;
      chk("dr_ready", 64'(dma_ready0), 64'd1);
      chk("dr_no_rvalid_after_write", 64'(dma_rvalid0), 64'd0);
      chk("dr_memwrite", 64'(me_memwrite0), 64'd0);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("dr_rvalid", 64'(dma_rvalid0), 64'd1);
      chk("dr_rdata", 64'(dma_rdata0), 64'hDEADBEEF);
      tick();
      chk("dr_rvalid_drop", 64'(dma_rvalid0), 64'd0);
      chk("dr_rdata_hold", 64'(dma_rdata0), 64'hDEADBEEF);

      // CPU preload of 0x030
      drive_cpu(1'b1, 1'b1, 12'h030, 32'h0000A5A5);
      #1;
      chk("cw_memwrite", 64'(me_memwrite0), 64'd1);
      tick();

      // Continuous contention: forced grant in cycle 8
      drive_cpu(1'b1, 1'b0, 12'h030, 32'h0);
      drive_dma(1'b1, 1'b0, 12'h010, 32'h0);
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("cont_ready_c%0d", c), 64'(dma_ready0), 64'd0);
         chk($sformatf("cont_stall_c%0d", c), 64'(cpu_stall0), 64'd0);
         chk($sformatf("cont_cnt_c%0d", c), 64'(cnt0), 64'(c));
         tick();
      end
      #1;
      chk("cont_state_c8", 64'(st0), 64'(FORCE));
      chk("cont_ready_c8", 64'(dma_ready0), 64'd1);
      chk("cont_stall_c8", 64'(cpu_stall0), 64'd1);
      chk("cont_addr_c8", 64'(me_address0), 64'h010);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("cont_stall_c9", 64'(cpu_stall0), 64'd0);
      chk("cont_state_c9", 64'(st0), 64'(IDLE));
      chk("cont_rvalid_c9", 64'(dma_rvalid0), 64'd1);
      chk("cont_rdata_c9", 64'(dma_rdata0), 64'hDEADBEEF);
      chk("cont_cpu_dout", 64'(cpu_dout0), 64'h0000A5A5);
      tick();

      // cpu_req drops in cycle 3 of contention
      drive_cpu(1'b1, 1'b0, 12'h030, 32'h0);
      drive_dma(1'b1, 1'b0, 12'h030, 32'h0);
      tick();
      tick();
      tick();
      chk("drop_state_c3", 64'(st0), 64'(WAIT));
      chk("drop_cnt_c3", 64'(cnt0), 64'd3);
      drive_cpu(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("drop_ready_c3", 64'(dma_ready0), 64'd1);
      chk("drop_stall_c3", 64'(cpu_stall0), 64'd0);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("drop_state_c4", 64'(st0), 64'(IDLE));
      chk("drop_cnt_c4", 64'(cnt0), 64'd0);
      chk("drop_rdata", 64'(dma_rdata0), 64'h0000A5A5);
      tick();

      // Forced DMA read vs stalled CPU write to the same address
      drive_dma(1'b1, 1'b1, 12'h020, 32'h11112222);
      tick();
      drive_cpu(1'b1, 1'b0, 12'h030, 32'h0);
      drive_dma(1'b1, 1'b0, 12'h020, 32'h0);
      for (int c = 0; c < 8; c++) tick();
      drive_cpu(1'b1, 1'b1, 12'h020, 32'h00000055);
      #1;
      chk("rw_stall", 64'(cpu_stall0), 64'd1);
      chk("rw_ready", 64'(dma_ready0), 64'd1);
      chk("rw_memwrite_stalled", 64'(me_memwrite0), 64'd0);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("rw_rvalid", 64'(dma_rvalid0), 64'd1);
      chk("rw_old_data", 64'(dma_rdata0), 64'h11112222);
      chk("rw_retry_memwrite", 64'(me_memwrite0), 64'd1);
      chk("rw_retry_stall", 64'(cpu_stall0), 64'd0);
      tick();
      drive_cpu(1'b1, 1'b0, 12'h020, 32'h0);
      #1;
      chk("rw_cpu_readback", 64'(cpu_dout0), 64'h00000055);
      tick();

      // Reset cancels a pending rvalid
      drive_cpu(1'b0, 1'b0, 12'h000, 32'h0);
      drive_dma(1'b1, 1'b0, 12'h010, 32'h0);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      chk("rc_rvalid_pre", 64'(dma_rvalid0), 64'd1);
      rst = 1'b1;
      #1;
      chk("rc_rvalid_cancel", 64'(dma_rvalid0), 64'd0);
      chk("rc_rdata_clear", 64'(dma_rdata0), 64'd0);
      rst = 1'b0;
      tick();

      // Reset asserted mid-WAIT
      drive_cpu(1'b1, 1'b0, 12'h030, 32'h0);
      drive_dma(1'b1, 1'b0, 12'h010, 32'h0);
      tick();
      tick();
      chk("rw_mid_state", 64'(st0), 64'(WAIT));
      chk("rw_mid_cnt", 64'(cnt0), 64'd2);
      rst = 1'b1;
      #1;
      chk("rst_mid_state", 64'(st0), 64'(IDLE));
      chk("rst_mid_cnt", 64'(cnt0), 64'd0);
      chk("rst_mid_rvalid", 64'(dma_rvalid0), 64'd0);
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_rel_ready", 64'(dma_ready0), 64'd0);
      tick();
      chk("rst_rel_ready2", 64'(dma_ready0), 64'd0);
      chk("rst_rel_state", 64'(st0), 64'(IDLE));
      chk("rst_rel_rvalid", 64'(dma_rvalid0), 64'd0);

      // STARVE_LIMIT=1 instance
      drive_cpu(1'b1, 1'b1, 12'h040, 32'h00000077);
      drive_dma(1'b1, 1'b0, 12'h050, 32'h0);
      #1;
      chk("l1_ready_c0", 64'(dma_ready1), 64'd0);
      chk("l1_memwrite_c0", 64'(me_memwrite1), 64'd1);
      tick();
      chk("l1_state_c1", 64'(st1), 64'(FORCE));
      chk("l1_ready_c1", 64'(dma_ready1), 64'd1);
      chk("l1_stall_c1", 64'(cpu_stall1), 64'd1);
      chk("l1_memwrite_c1", 64'(me_memwrite1), 64'd0);
      tick();
      drive_dma(1'b0, 1'b0, 12'h000, 32'h0);
      #1;
      chk("l1_stall_c2", 64'(cpu_stall1), 64'd0);
      chk("l1_memwrite_c2", 64'(me_memwrite1), 64'd1);
      chk("l1_rvalid_c2", 64'(dma_rvalid1), 64'd1);
      chk("l1_state_c2", 64'(st1), 64'(IDLE));
      tick();
      drive_cpu(1'b0, 1'b0, 12'h000, 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
